// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - request/ready memory responder with programmable wait states
// Little-endian byte array; byte/half/word loads and stores; misaligned or out-of-range requests answer with err.
module mem_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [1:0]           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 wr_q, sext_q, bad_q;
  logic [1:0]           size_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [31:0]          rdata_q, rdata_d;
  logic                 ready_q, err_q, busy_q;

  logic [7:0] mem_q [DEPTH];

  logic                 accept, bad_in, do_acc;
  logic                 a_wr, a_sext;
  logic [1:0]           a_size;
  logic [ADDR_BITS-1:0] a0, a1, a2, a3;
  logic [31:0]          a_wdata, load_val;
  logic [7:0]           b0, b1, b2, b3;

  assign accept = (state_q == S_IDLE) && req;

  assign bad_in = (size == 2'b11)
               || ((size == 2'b01) && addr[0])
               || ((size == 2'b10) && (addr[1:0] != 2'b00))
               || ((addr >> ADDR_BITS) != 32'd0);

  // With zero wait states the access happens on the accepting edge, so use the live inputs there.
  assign a_wr    = accept ? wr                   : wr_q;
  assign a_size  = accept ? size                 : size_q;
  assign a_sext  = accept ? sign_ext             : sext_q;
  assign a0      = accept ? addr[ADDR_BITS-1:0]  : addr_q;
  assign a_wdata = accept ? wdata                : wdata_q;
  assign a1      = a0 + ADDR_BITS'(1);
  assign a2      = a0 + ADDR_BITS'(2);
  assign a3      = a0 + ADDR_BITS'(3);

  assign b0 = mem_q[a0];
  assign b1 = mem_q[a1];
  assign b2 = mem_q[a2];
  assign b3 = mem_q[a3];

  always_comb begin
    load_val = '0;
    case (a_size)
      2'b00:   load_val = {{24{a_sext & b0[7]}}, b0};
      2'b01:   load_val = {{16{a_sext & b1[7]}}, b1, b0};
      default: load_val = {b3, b2, b1, b0};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    do_acc  = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (bad_in) begin
            state_d = S_RESP;
            rdata_d = '0;
          end else if (WAIT_STATES == 0) begin
            do_acc  = 1'b1;
            state_d = S_RESP;
          end else begin
            cnt_d   = 4'(WAIT_STATES);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          do_acc  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (do_acc) rdata_d = a_wr ? 32'd0 : load_val;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      if (accept) begin
        wr_q    <= wr;
        size_q  <= size;
        sext_q  <= sign_ext;
        addr_q  <= addr[ADDR_BITS-1:0];
        wdata_q <= wdata;
        bad_q   <= bad_in;
      end
      ready_q <= (state_q == S_RESP);
      err_q   <= (state_q == S_RESP) && bad_q;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  // Array is not reset; a reset landing on the access edge must still suppress the store.
  always_ff @(posedge clk) begin
    if (do_acc && a_wr && !reset) begin
      mem_q[a0] <= a_wdata[7:0];
      if (a_size != 2'b00) mem_q[a1] <= a_wdata[15:8];
      if (a_size == 2'b10) begin
        mem_q[a2] <= a_wdata[23:16];
        mem_q[a3] <= a_wdata[31:24];
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed bench for mem_responder at WAIT_STATES 1, 3 and 0
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset_a = 1'b0, reset_b = 1'b0, reset_c = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
  logic        wr = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;

  logic [31:0] rdata_a, rdata_b, rdata_c;
  logic        ready_a, ready_b, ready_c;
  logic        err_a, err_b, err_c;
  logic        busy_a, busy_b, busy_c;

  int          sel = 0;
  logic [31:0] m_rdata;
  logic        m_ready, m_err, m_busy;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_BITS(8), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset_a), .req(req_a), .wr(wr), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata_a), .ready(ready_a), .err(err_a), .busy(busy_a));

  mem_responder #(.ADDR_BITS(8), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset_b), .req(req_b), .wr(wr), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata_b), .ready(ready_b), .err(err_b), .busy(busy_b));

  mem_responder #(.ADDR_BITS(8), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset_c), .req(req_c), .wr(wr), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata_c), .ready(ready_c), .err(err_c), .busy(busy_c));

  always_comb begin
    m_rdata = rdata_a; m_ready = ready_a; m_err = err_a; m_busy = busy_a;
    if (sel == 1) begin
      m_rdata = rdata_b; m_ready = ready_b; m_err = err_b; m_busy = busy_b;
    end else if (sel == 2) begin
      m_rdata = rdata_c; m_ready = ready_c; m_err = err_c; m_busy = busy_c;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int s, input logic v);
    case (s)
      0: req_a = v;
      1: req_b = v;
      default: req_c = v;
    endcase
  endtask

  // One request; measures cycles from the accepting edge to the ready pulse.
  task automatic txn(input int s, input logic w, input logic [1:0] sz, input logic se,
                     input logic [31:0] ad, input logic [31:0] wd, input int exp_lat,
                     input logic exp_err, input logic [31:0] exp_rd, input string tag);
    int  lat;
    bit  got;
    sel = s; wr = w; size = sz; sign_ext = se; addr = ad; wdata = wd;
    set_req(s, 1'b1);
    @(posedge clk); #1;
    set_req(s, 1'b0);
    wr = ~w; size = ~sz; addr = ~ad; wdata = ~wd; sign_ext = ~se;
    check({tag, "_busy"}, 32'(m_busy), 32'(1));
    lat = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (m_ready) got = 1;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_err"}, 32'(m_err), 32'(exp_err));
    check({tag, "_rdata"}, m_rdata, exp_rd);
    @(posedge clk); #1;
    check({tag, "_ready_drop"}, 32'(m_ready), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    reset_a = 1'b1; reset_b = 1'b1; reset_c = 1'b1;
    #1;
    check("rst_ready", 32'({ready_a, ready_b, ready_c}), 32'(0));
    check("rst_err", 32'({err_a, err_b, err_c}), 32'(0));
    check("rst_busy", 32'({busy_a, busy_b, busy_c}), 32'(0));
    check("rst_rdata", rdata_a | rdata_b | rdata_c, 32'h0);
    @(negedge clk);
    reset_a = 1'b0; reset_b = 1'b0; reset_c = 1'b0;

    // WAIT_STATES = 1
    txn(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0, "st_w10");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF, "ld_w10");
    txn(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'h000000EF, "ld_b10u");
    txn(0, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 2, 1'b0, 32'hFFFFFFDE, "ld_b13s");
    txn(0, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 2, 1'b0, 32'h0000DEAD, "ld_h12u");
    txn(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 1'b0, 32'hFFFFDEAD, "ld_h12s");
    txn(0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAAAA55, 2, 1'b0, 32'h0, "st_b11");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEAD55EF, "ld_w10b");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h02, 32'h0, 1, 1'b1, 32'h0, "err_w02");
    txn(0, 1'b1, 2'b01, 1'b0, 32'h11, 32'h01020304, 1, 1'b1, 32'h0, "err_h11");
    txn(0, 1'b1, 2'b11, 1'b0, 32'h10, 32'h01020304, 1, 1'b1, 32'h0, "err_sz3");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'h0, "err_oob");
    txn(0, 1'b1, 2'b10, 1'b0, 32'h110, 32'h11111111, 1, 1'b1, 32'h0, "err_oobst");
    txn(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEAD55EF, "ld_w10c");

    // WAIT_STATES = 3, reset while the store is still waiting
    txn(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 4, 1'b0, 32'h0, "b_st20");
    txn(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 4, 1'b0, 32'hCAFEF00D, "b_ld20");
    sel = 1; wr = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h20; wdata = 32'h12345678;
    req_b = 1'b1;
    @(posedge clk); #1;
    req_b = 1'b0;
    @(posedge clk); #1;
    check("b_wait_busy", 32'(busy_b), 32'(1));
    check("b_wait_ready", 32'(ready_b), 32'(0));
    #2;
    reset_b = 1'b1;
    #1;
    check("b_rst_busy", 32'(busy_b), 32'(0));
    check("b_rst_ready", 32'(ready_b), 32'(0));
    check("b_rst_rdata", rdata_b, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    reset_b = 1'b0;
    check("b_idle_busy", 32'(busy_b), 32'(0));
    txn(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 4, 1'b0, 32'hCAFEF00D, "b_ld20_keep");
    txn(1, 1'b0, 2'b00, 1'b1, 32'h20, 32'h0, 4, 1'b0, 32'h0000000D, "b_ld_b20s");

    // WAIT_STATES = 0, request held high
    txn(2, 1'b1, 2'b10, 1'b0, 32'h04, 32'h0A0B0C8D, 1, 1'b0, 32'h0, "c_st04");
    txn(2, 1'b0, 2'b00, 1'b1, 32'h04, 32'h0, 1, 1'b0, 32'hFFFFFF8D, "c_ld_b04s");
    sel = 2; wr = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h04; wdata = 32'h0;
    req_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check($sformatf("c_hold_busy%0d", i), 32'(busy_c), 32'(((i % 2) == 0) ? 1 : 0));
      check($sformatf("c_hold_ready%0d", i), 32'(ready_c), 32'(((i % 2) == 1) ? 1 : 0));
      if ((i % 2) == 1) check($sformatf("c_hold_rdata%0d", i), rdata_c, 32'h0A0B0C8D);
    end
    req_c = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("c_release_busy", 32'(busy_c), 32'(0));
      check("c_release_ready", 32'(ready_c), 32'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
